// File: rtl/image_read_pkg.sv
// image_read shared types: config register codes, FSM states, config bundle.
// Codes are distinct from the image_write register codes.
package image_read_pkg;

  localparam int CFG_IR_IMG_W = 16;
  localparam int CFG_IR_START = 17;
  localparam int CFG_IR_STEP  = 18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] img_w;
    logic [15:0] start;
    logic [15:0] img_h;
    logic [15:0] step_p;
    logic [15:0] step_r;
  } cfg_t;

  function automatic logic [31:0] row_stride(cfg_t c);
    return (32'(c.step_p) + 32'd1) * (32'(c.step_r) + 32'd1);
  endfunction

endpackage

// File: rtl/image_read_if.sv
// image_read output stream: valid/ready handshake carrying one word of
// DEPTH_NB pixels per beat.
interface image_read_if #(
  parameter int W = 256
) ();

  logic [W-1:0] str_img_bus;
  logic         str_img_val;
  logic         str_img_rdy;

  modport master (
    output str_img_bus,
    output str_img_val,
    input  str_img_rdy
  );

  modport slave (
    input  str_img_bus,
    input  str_img_val,
    output str_img_rdy
  );

endinterface

// File: rtl/image_read_fifo.sv
// image_read output buffer: synchronous FIFO, head visible on rd_data,
// occupancy exported for the read-credit check.
module image_read_fifo #(
  parameter int W     = 256,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;

  assign pop     = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/image_read.sv
// image_read: walks an image in image_mem and streams it out word by word.
// Define IMAGE_READ_PERF_EN to add the stall_cnt output-stall counter.
module image_read
  import image_read_pkg::*;
#(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int DEPTH_NB   = 16,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic                          next,
  output logic                          rd_val,
  output logic [MEM_AWIDTH-1:0]         rd_addr,
  input  logic [IMG_WIDTH*DEPTH_NB-1:0] rd_data,
  image_read_if.master                  str,
  output logic                          busy
`ifdef IMAGE_READ_PERF_EN
  ,
  output logic [31:0]                   stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = IMG_WIDTH * DEPTH_NB;

  state_t state, state_n;
  cfg_t   shd;

  logic [31:0] d32;
  logic [31:0] cur_img_w;
  logic [15:0] cur_img_h;
  logic [15:0] cur_step_p;
  logic [15:0] cur_start;
  logic [31:0] sp1;
  logic [31:0] rstride;

  logic [31:0] w;
  logic [15:0] h;
  logic [15:0] d;

  logic start_img;
  logic issue;
  logic last_all;
  logic credit_ok;

  logic                  s1_val;
  logic [31:0]           s1_a;
  logic [31:0]           s1_b;
  logic [31:0]           s1_c;
  logic                  s2_val;
  logic [MEM_AWIDTH-1:0] s2_sum;

  logic [RD_LATENCY-1:0] vpipe;
  logic                  wr_en;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fcount;
  logic [CW:0]           used;
  logic [BW-1:0]         head;

  assign d32 = 32'(cfg_data);

  // Shadow registers: writable at any time, only sampled on an accepted next.
  always_ff @(posedge clk) begin
    if (cfg_valid) begin
      case (cfg_addr)
        CFG_AWIDTH'(CFG_IR_IMG_W): shd.img_w <= d32;
        CFG_AWIDTH'(CFG_IR_START): begin
          shd.start <= d32[31:16];
          shd.img_h <= d32[15:0];
        end
        CFG_AWIDTH'(CFG_IR_STEP): begin
          shd.step_p <= d32[31:16];
          shd.step_r <= d32[15:0];
        end
        default: ;
      endcase
    end
  end

  assign start_img = (state == S_IDLE) && next;

  always_ff @(posedge clk) begin
    if (start_img) begin
      cur_img_w  <= shd.img_w;
      cur_img_h  <= shd.img_h;
      cur_step_p <= shd.step_p;
      cur_start  <= shd.start;
      sp1        <= 32'(shd.step_p) + 32'd1;
      rstride    <= row_stride(shd);
    end
  end

  assign used      = {1'b0, inflight} + {1'b0, fcount};
  assign credit_ok = used < (CW+1)'(FIFO_DEPTH);
  assign last_all  = (w == cur_img_w) && (h == cur_img_h)
                  && (d == cur_step_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    unique case (state)
      S_IDLE:  if (next) state_n = S_ISSUE;
      S_ISSUE: begin
        issue = credit_ok;
        if (issue && last_all) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (inflight == '0 && fcount == '0) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w <= '0;
      h <= '0;
      d <= '0;
    end else if (start_img) begin
      w <= '0;
      h <= '0;
      d <= '0;
    end else if (issue) begin
      if (w != cur_img_w) begin
        w <= w + 32'd1;
      end else begin
        w <= '0;
        if (h != cur_img_h) begin
          h <= h + 16'd1;
        end else begin
          h <= '0;
          d <= d + 16'd1;
        end
      end
    end
  end

  // Three-stage address pipe: partial products, sum, output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_val <= 1'b0;
      s2_val <= 1'b0;
      rd_val <= 1'b0;
    end else begin
      s1_val <= issue;
      s2_val <= s1_val;
      rd_val <= s2_val;
    end
  end

  always_ff @(posedge clk) begin
    s1_a    <= 32'(cur_start) + 32'(d);
    s1_b    <= w * sp1;
    s1_c    <= 32'(h) * rstride;
    s2_sum  <= MEM_AWIDTH'(s1_a + s1_b + s1_c);
    rd_addr <= s2_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= rd_val;
      for (int i = 1; i < RD_LATENCY; i++)
        vpipe[i] <= vpipe[i-1];
    end
  end

  assign wr_en = vpipe[RD_LATENCY-1];

  // Credits cover every read between issue and its FIFO write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= '0;
    else        inflight <= inflight + CW'(issue) - CW'(wr_en);
  end

  image_read_fifo #(
    .W     (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (rd_data),
    .rd_en   (str.str_img_rdy),
    .rd_data (head),
    .count   (fcount)
  );

  assign str.str_img_val = (fcount != '0);
  assign str.str_img_bus = head;

`ifdef IMAGE_READ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (start_img) begin
      stall_cnt <= '0;
    end else if (str.str_img_val && !str.str_img_rdy
                 && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/image_read.md
IMAGE_READ -- requirements
Module: image_read

Interface
REQ-001 SHALL have parameter CFG_DWIDTH, default 32, configuration data width.
REQ-002 SHALL have parameter CFG_AWIDTH, default 5, configuration address width.
REQ-003 SHALL have parameter DEPTH_NB, default 16, pixels (depth slices) per word.
REQ-004 SHALL have parameter IMG_WIDTH, default 16, bits per pixel.
REQ-005 SHALL have parameter MEM_AWIDTH, default 16, image_mem address width, <32.
REQ-006 SHALL have parameter RD_LATENCY, default 2, image_mem read latency in cycles.
REQ-007 SHALL have parameter FIFO_DEPTH, default 8, output buffer entries, power of two, >= RD_LATENCY+4.
REQ-008 SHALL have ports: clk in 1 clock; rst_n in 1 reset (one clock; reset is asynchronous and active-low).
REQ-009 SHALL have ports cfg_data in CFG_DWIDTH, cfg_addr in CFG_AWIDTH, cfg_valid in 1: configuration write bus.
REQ-010 SHALL have port next in 1: latch configuration and start one image read.
REQ-011 SHALL have ports rd_val out 1, rd_addr out MEM_AWIDTH: image_mem read request.
REQ-012 SHALL have port rd_data in IMG_WIDTH*DEPTH_NB: read data, valid RD_LATENCY cycles after rd_val.
REQ-013 SHALL have ports str_img_bus out IMG_WIDTH*DEPTH_NB, str_img_val out 1, str_img_rdy in 1: output stream.
REQ-014 SHALL have port busy out 1: high whenever the FSM is not IDLE.

Function
REQ-015 SHALL capture cfg registers CFG_IR_IMG_W (img_w, 32b), CFG_IR_START ([31:16] start, [15:0] img_h), CFG_IR_STEP ([31:16] step_p, [15:0] step_r) on cfg_valid with matching cfg_addr.
REQ-016 SHALL treat all config values as zero-indexed: counts are value+1, start is the literal address.
REQ-017 SHALL run FSM IDLE -> ISSUE on next in IDLE; ISSUE -> DRAIN after the final address is issued; DRAIN -> IDLE when in-flight count and FIFO are both zero.
REQ-018 SHALL ignore next outside IDLE and SHALL NOT alter latched config while busy.
REQ-019 SHALL iterate counters w (innermost, 0..img_w), h (0..img_h), d (outermost, 0..step_p cfg value).
REQ-020 SHALL compute address = start + d + w*(step_p+1) + h*(step_p+1)*(step_r+1), truncated to MEM_AWIDTH, with 32-bit intermediates.
REQ-021 SHALL pipeline address computation so rd_val/rd_addr appear exactly 3 cycles after counter issue.
REQ-022 SHALL issue a counter step only while in-flight reads plus FIFO occupancy < FIFO_DEPTH; the FIFO SHALL never overflow or drop data.
REQ-023 SHALL write rd_data into the FIFO exactly RD_LATENCY cycles after each rd_val, preserving issue order.
REQ-024 SHALL present FIFO head registered: str_img_val high when non-empty; beat transfers on str_img_val & str_img_rdy; str_img_bus held stable while stalled.
REQ-025 SHALL sustain one beat per cycle with str_img_rdy constantly high; first beat str_img_val 7 cycles after next for RD_LATENCY=2.
REQ-026 SHALL deliver exactly (img_w+1)*(img_h+1)*(step_p+1) beats per next.

Reset
REQ-027 SHALL, on rst_n low asynchronously, set FSM IDLE, counters, in-flight count, FIFO pointers, rd_val, str_img_val, busy to 0; config registers and data paths are not reset.
REQ-028 SHALL abort mid-operation on reset: pending reads discarded, no beat emitted until a new next.

Configuration
REQ-029 SHALL, with IMAGE_READ_PERF_EN defined, add output stall_cnt (32b) counting cycles of str_img_val & ~str_img_rdy, cleared on next and reset, saturating at all-ones.
REQ-030 SHALL, without IMAGE_READ_PERF_EN, omit stall_cnt port and logic entirely; all other behaviour identical.

Structure
REQ-031 SHALL take CFG_IR_IMG_W, CFG_IR_START, CFG_IR_STEP from the shared cfg_parameters.vh, distinct from the image_write codes.
REQ-032 SHALL instantiate one sub-module image_read_fifo (synchronous FIFO, FIFO_DEPTH entries, count output).

Verification
REQ-033 img_w=2, img_h=1, step_p=0, step_r=3, start=0x10, rdy high -> rd_addr 0x10,0x11,0x12,0x14,0x15,0x16, 6 beats in order, busy falls after last.
REQ-034 Same config, step_p=1 -> 12 reads, d=0 pass at 0x10,0x12,0x14,0x18,0x1A,0x1C then d=1 pass +1.
REQ-035 str_img_rdy low 20 cycles mid-image -> rd_val stops after FIFO fills, no overflow, no data lost, bus stable while stalled.
REQ-036 next pulsed while busy with different cfg writes -> current image completes unchanged, second next ignored.
REQ-037 rst_n asserted mid-ISSUE -> rd_val, str_img_val, busy low immediately; new next yields a clean full image.
REQ-038 IMAGE_READ_PERF_EN defined, rdy low 5 cycles with valid high -> stall_cnt = 5.
